game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 31 +++
 rtl/lfsr16.sv | 29 ++
 rtl/game_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the falling-block game: FSM state encodings,
// parameter defaults and a small saturating helper. The display logic
// imports this package as well, so it can decode the exported state.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPAWN  = 3'd1,
        ST_FALL   = 3'd2,
        ST_LAND   = 3'd3,
        ST_PAUSED = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    localparam int          TICK_DIV_DEF   = 250000;
    localparam int          FALL_STEP_DEF  = 2;
    localparam int          FLOOR_Y_DEF    = 480;
    localparam int          X_MAX_DEF      = 490;
    localparam int          MAX_HEIGHT_DEF = 16;
    localparam int          LIVES_INIT_DEF = 3;
    localparam logic [15:0] LFSR_SEED      = 16'hACE1;

    // 10-bit add that clips at 1023 instead of wrapping.
    function automatic logic [9:0] sat_add10(input logic [9:0] a,
                                             input logic [9:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[10] ? 10'h3FF : s[9:0];
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR (taps 16,14,13,11), free running.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset, loads the seed
//   q     - current LFSR contents
// A non-zero seed with a maximal polynomial never reaches all-zero.
import game_pkg::*;

module lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];
    assign q    = r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= {r_q[14:0], w_fb};
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer for the falling-block stacker: spawns a block at a
// pseudo-random x, lets it fall one step per tick, and scores landings
// or charges misses until the lives run out or the stack is tall enough.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   start, pause_btn    - level buttons, acted upon on their rising edge
//   collision           - falling block touches the stack this cycle
//   height              - current stack height in blocks
//   fall_x, fall_y      - falling block top-left position
//   fall_color          - falling block color
//   fall_valid          - falling block is live (FALL only)
//   pause               - freezes stack movement (IDLE, PAUSED, OVER)
//   stack_clear         - one-cycle pulse clearing the stack at game start
//   score, lives        - landed-block count, remaining lives
//   game_over           - sticky until the next game starts
//   state               - current FSM encoding
import game_pkg::*;

module game_ctrl #(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int FALL_STEP  = FALL_STEP_DEF,
    parameter int FLOOR_Y    = FLOOR_Y_DEF,
    parameter int X_MAX      = X_MAX_DEF,
    parameter int MAX_HEIGHT = MAX_HEIGHT_DEF,
    parameter int LIVES_INIT = LIVES_INIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause_btn,
    input  logic        collision,
    input  logic [9:0]  height,
    output logic [9:0]  fall_x,
    output logic [9:0]  fall_y,
    output logic [1:0]  fall_color,
    output logic        fall_valid,
    output logic        pause,
    output logic        stack_clear,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic [2:0]  state
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_start_q;
    logic        r_pause_q;
    logic [31:0] r_tick_cnt;
    logic [9:0]  r_fall_x;
    logic [9:0]  r_fall_y;
    logic [1:0]  r_fall_color;
    logic [15:0] r_score;
    logic [1:0]  r_lives;
    logic        r_game_over;

    logic [15:0] w_lfsr;
    logic [3:0]  w_lfsr_unused;
    logic        w_start_edge;
    logic        w_pause_edge;
    logic        w_tick;
    logic        w_floor;
    logic        w_tall;
    logic        w_last_life;
    logic        w_begin;
    logic        w_miss;
    logic        w_advance;
    logic        w_land;
    logic [9:0]  w_spawn_x;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (w_lfsr)
    );

    assign w_lfsr_unused = w_lfsr[15:12];

    assign w_start_edge = start & ~r_start_q;
    assign w_pause_edge = pause_btn & ~r_pause_q;
    assign w_tick       = (r_state == ST_FALL) && (r_tick_cnt == 32'(TICK_DIV - 1));
    assign w_floor      = r_fall_y >= 10'(FLOOR_Y);
    assign w_tall       = height >= 10'(MAX_HEIGHT);
    assign w_last_life  = r_lives <= 2'd1;
    assign w_spawn_x    = (w_lfsr[9:0] > 10'(X_MAX)) ? 10'(X_MAX) : w_lfsr[9:0];

    assign fall_x     = r_fall_x;
    assign fall_y     = r_fall_y;
    assign fall_color = r_fall_color;
    assign score      = r_score;
    assign lives      = r_lives;
    assign game_over  = r_game_over;
    assign state      = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_begin     = 1'b0;
        w_miss      = 1'b0;
        w_advance   = 1'b0;
        w_land      = 1'b0;
        fall_valid  = 1'b0;
        pause       = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                pause = 1'b1;
                if (w_start_edge) begin
                    w_begin     = 1'b1;
                    w_state_nxt = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                w_state_nxt = ST_FALL;
            end
            ST_FALL: begin
                fall_valid = 1'b1;
                // Collision wins over the floor so a last-moment touch scores.
                if (collision) begin
                    w_state_nxt = ST_LAND;
                end else if (w_floor) begin
                    w_miss      = 1'b1;
                    w_state_nxt = w_last_life ? ST_OVER : ST_SPAWN;
                end else begin
                    w_advance = w_tick;
                    if (w_pause_edge) begin
                        w_state_nxt = ST_PAUSED;
                    end
                end
            end
            ST_LAND: begin
                w_land      = 1'b1;
                w_state_nxt = w_tall ? ST_OVER : ST_SPAWN;
            end
            ST_PAUSED: begin
                pause = 1'b1;
                if (w_pause_edge) begin
                    w_state_nxt = ST_FALL;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        stack_clear = w_begin & rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start_q    <= 1'b0;
            r_pause_q    <= 1'b0;
            r_tick_cnt   <= '0;
            r_fall_x     <= '0;
            r_fall_y     <= '0;
            r_fall_color <= '0;
            r_score      <= '0;
            r_lives      <= 2'(LIVES_INIT);
            r_game_over  <= 1'b0;
        end else begin
            r_start_q <= start;
            r_pause_q <= pause_btn;

            // Counter holds while paused so resuming keeps the tick phase.
            if (r_state == ST_FALL) begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 32'd1;
            end else if (r_state != ST_PAUSED) begin
                r_tick_cnt <= '0;
            end

            if (r_state == ST_SPAWN) begin
                r_fall_x     <= w_spawn_x;
                r_fall_y     <= '0;
                r_fall_color <= w_lfsr[11:10];
            end else if (w_advance) begin
                r_fall_y <= sat_add10(r_fall_y, 10'(FALL_STEP));
            end else if (w_land) begin
                // Park the block at the top so it leaves the collision window.
                r_fall_y <= '0;
            end

            if (w_begin) begin
                r_score     <= '0;
                r_lives     <= 2'(LIVES_INIT);
                r_game_over <= 1'b0;
            end else if (w_miss) begin
                r_lives <= (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
                if (w_last_life) begin
                    r_game_over <= 1'b1;
                end
            end else if (w_land) begin
                if (r_score != 16'hFFFF) begin
                    r_score <= r_score + 16'd1;
                end
                if (w_tall) begin
                    r_game_over <= 1'b1;
                end
            end
        end
    end

endmodule
